neuron_mac: RTL and testbench
=============================

Name: neuron_mac

Overview:
- Single-neuron compute stage sitting directly downstream of a per-neuron weight memory.
- Consumes one activation per valid cycle and drives the weight memory's read enable and read address.
- Multiplies each activation by the weight returned one cycle later and accumulates numWeight products.
- Adds the neuron bias, rescales, saturates and optionally applies ReLU, then emits one output value per frame to the next layer.

Parameters:
- numWeight, 10, number of inputs/weights per neuron (frame length)
- addressWidth, $clog2(numWeight), weight address width
- dataWidth, 16, width of activations, weights, bias and output (signed two's complement)
- fracBits, 8, fractional bits of the shared fixed-point format

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  dataWidth  signed activation
- in_valid  in  1  in_data valid this cycle; no backpressure
- bias  in  dataWidth  signed neuron bias, held stable by upstream
- w_ren  out  1  weight memory read enable
- w_radd  out  addressWidth  weight memory read address
- w_rdata  in  dataWidth  weight from memory, valid the cycle after w_ren
- out_data  out  dataWidth  neuron result, registered
- out_valid  out  1  one-cycle pulse, out_data valid

Behaviour:
- Reset: one clock and an asynchronous active-low reset on rst_n (port names clk and rst_n).
- Asserting rst_n low immediately clears all state, including mid-frame: w_radd=0, addr counter=0, pipeline valids=0, accumulator=0, out_data=0, out_valid=0.
- w_ren = in_valid (combinational).
- w_radd = address counter register.
- Address counter:
  - increments on each in_valid;
  - wraps to 0 after numWeight-1;
  - gaps in in_valid hold the counter (stall).
- Stage 1 (edge after the in_valid cycle t): register in_data delayed by 1 cycle so it aligns with w_rdata. At t+1, register the full-precision product p = in_d * w_rdata (2*dataWidth signed), with flags valid_m and last_m (last_m = address was numWeight-1).
- Stage 2 (t+2): acc <= acc + p when valid_m.
  - acc width: 2*dataWidth+addressWidth signed; never overflows.
  - last_m propagates to last_a.
- Stage 3 (t+3), when last_a:
  - s = acc + (sign-extended bias << fracBits);
  - r = s >>> fracBits (arithmetic, floor);
  - saturate r to [-2^(dataWidth-1), 2^(dataWidth-1)-1];
  - apply the activation (see Optional Feature);
  - register into out_data and pulse out_valid for exactly 1 cycle.
- Latency: out_valid is high in cycle t_last+3, where t_last is the cycle carrying the numWeight-th in_valid.
- out_data holds its value until the next result.
- Accumulator restart: in the same edge that last_a is consumed, acc loads p if valid_m, else 0. Back-to-back frames with no idle cycle are therefore exact.
- Frames are continuous: after wrap, the next in_valid is weight 0 of a new frame.
- bias is sampled only at stage 3.

Optional Feature:
- Macro: NEURON_RELU_EN.
- Defined: out_data = 0 when the saturated result is negative, else the saturated result.
- Undefined: out_data = the saturated result (linear activation).

Test Plan:
- Weights all 0x0100, 10 inputs 0x0100, bias 0 -> w_radd 0..9, one out_valid 3 cycles after the 10th in_valid, out_data 0x0A00.
- Weights 0xFF00, inputs 0x0100, bias 0 -> out_data 0x0000 with NEURON_RELU_EN, 0xF600 without.
- Weights 0x7FFF, inputs 0x7FFF, bias 0x7FFF -> out_data 0x7FFF (positive saturation). Weights 0x8000, inputs 0x7FFF without NEURON_RELU_EN -> 0x8000.
- Test 1 stimulus with random 1-3 cycle in_valid gaps, bias 0x0080 -> out_data 0x0A80, w_radd held during gaps, single out_valid.
- 20 consecutive in_valid (two frames, second frame inputs 0x0200, weights 0x0100) -> out_valid pulses 10 cycles apart, out_data 0x0A00 then 0x1400, no cross-frame leakage.
- Assert rst_n low after 5 inputs -> immediately out_valid=0, out_data=0, w_radd=0. After release, a full frame per test 1 -> 0x0A00.

Source files
------------

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate stage fed by a per-neuron weight memory.
// Optional ReLU activation enabled by defining NEURON_RELU_EN (linear otherwise).
module neuron_mac #(
    parameter int numWeight    = 10,
    parameter int addressWidth = $clog2(numWeight),
    parameter int dataWidth    = 16,
    parameter int fracBits     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [dataWidth-1:0]    in_data,
    input  logic                           in_valid,
    input  logic signed [dataWidth-1:0]    bias,
    output logic                           w_ren,
    output logic        [addressWidth-1:0] w_radd,
    input  logic signed [dataWidth-1:0]    w_rdata,
    output logic signed [dataWidth-1:0]    out_data,
    output logic                           out_valid
);

    localparam int PW   = 2 * dataWidth;
    localparam int ACCW = 2 * dataWidth + addressWidth;

    localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);
    localparam logic [addressWidth-1:0] ADDR_ONE  = addressWidth'(1);
    localparam logic signed [ACCW-1:0]  SAT_MAX   = {{(ACCW-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
    localparam logic signed [ACCW-1:0]  SAT_MIN   = {{(ACCW-dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};

    function automatic logic signed [dataWidth-1:0] saturate(input logic signed [ACCW-1:0] v);
        logic signed [dataWidth-1:0] res;
        if (v > SAT_MAX) begin
            res = SAT_MAX[dataWidth-1:0];
        end else if (v < SAT_MIN) begin
            res = SAT_MIN[dataWidth-1:0];
        end else begin
            res = v[dataWidth-1:0];
        end
        return res;
    endfunction

    logic        [addressWidth-1:0] addr_q,     addr_d;
    logic signed [dataWidth-1:0]    in_d_q,     in_d_d;
    logic                           valid_m_q,  valid_m_d;
    logic                           last_m_q,   last_m_d;
    logic signed [ACCW-1:0]         acc_q,      acc_d;
    logic                           last_a_q,   last_a_d;
    logic signed [dataWidth-1:0]    out_data_q, out_data_d;
    logic                           out_valid_q, out_valid_d;

    logic signed [PW-1:0]           p_s;
    logic signed [ACCW-1:0]         p_ext_s;
    logic signed [ACCW-1:0]         bias_sh_s;
    logic signed [ACCW-1:0]         sum_s;
    logic signed [ACCW-1:0]         scaled_s;
    logic signed [dataWidth-1:0]    sat_s;
    logic signed [dataWidth-1:0]    act_s;

    assign w_ren     = in_valid;
    assign w_radd    = addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    // Delayed activation meets the weight that the memory returns this cycle.
    assign p_s       = $signed({{dataWidth{in_d_q[dataWidth-1]}}, in_d_q})
                     * $signed({{dataWidth{w_rdata[dataWidth-1]}}, w_rdata});
    assign p_ext_s   = $signed({{addressWidth{p_s[PW-1]}}, p_s});
    assign bias_sh_s = $signed({{(ACCW-dataWidth-fracBits){bias[dataWidth-1]}}, bias, {fracBits{1'b0}}});
    assign sum_s     = acc_q + bias_sh_s;
    assign scaled_s  = sum_s >>> fracBits;
    assign sat_s     = saturate(scaled_s);

    // Activation function applied to the saturated result
    always_comb begin
        act_s = sat_s;
`ifdef NEURON_RELU_EN
        if (sat_s[dataWidth-1]) begin
            act_s = {dataWidth{1'b0}};
        end else begin
            act_s = sat_s;
        end
`else
        act_s = sat_s;
`endif
    end

    // Next-state logic for address counter, pipeline flags, accumulator and output
    always_comb begin
        addr_d      = addr_q;
        in_d_d      = in_d_q;
        valid_m_d   = in_valid;
        last_m_d    = 1'b0;
        acc_d       = acc_q;
        last_a_d    = valid_m_q & last_m_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;

        if (in_valid) begin
            in_d_d   = in_data;
            last_m_d = (addr_q == LAST_ADDR);
            if (addr_q == LAST_ADDR) begin
                addr_d = {addressWidth{1'b0}};
            end else begin
                addr_d = addr_q + ADDR_ONE;
            end
        end else begin
            addr_d = addr_q;
        end

        // A finished frame restarts the sum with whatever product arrives alongside it.
        if (last_a_q) begin
            acc_d = valid_m_q ? p_ext_s : {ACCW{1'b0}};
        end else if (valid_m_q) begin
            acc_d = acc_q + p_ext_s;
        end else begin
            acc_d = acc_q;
        end

        if (last_a_q) begin
            out_data_d  = act_s;
            out_valid_d = 1'b1;
        end else begin
            out_data_d  = out_data_q;
            out_valid_d = 1'b0;
        end
    end

    // State registers, cleared immediately by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= {addressWidth{1'b0}};
            in_d_q      <= {dataWidth{1'b0}};
            valid_m_q   <= 1'b0;
            last_m_q    <= 1'b0;
            acc_q       <= {ACCW{1'b0}};
            last_a_q    <= 1'b0;
            out_data_q  <= {dataWidth{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            in_d_q      <= in_d_d;
            valid_m_q   <= valid_m_d;
            last_m_q    <= last_m_d;
            acc_q       <= acc_d;
            last_a_q    <= last_a_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: table-driven frames, corner sequences and random frames.
module tb_neuron_mac;
    localparam int NW = 10;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic signed [15:0] bias;
    logic               w_ren;
    logic        [3:0]  w_radd;
    logic signed [15:0] w_rdata;
    logic signed [15:0] out_data;
    logic               out_valid;

    neuron_mac dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .bias(bias),
        .w_ren(w_ren), .w_radd(w_radd), .w_rdata(w_rdata),
        .out_data(out_data), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight memory: synchronous read, data one cycle after the enable
    logic signed [15:0] wmem [NW];
    always @(posedge clk) if (w_ren) w_rdata <= wmem[w_radd];

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct { int cyc; logic signed [15:0] val; } exp_t;
    exp_t expq[$];
    int model_addr = 0;
    int pulses = 0;
    logic signed [15:0] last_out = 16'sd0;
    int fidx = 0;
    longint fsum = 0;

    function automatic logic signed [15:0] ref_out(input longint sum, input logic signed [15:0] b);
        longint r;
        r = (sum + longint'(b) * 256) >>> 8;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`ifdef NEURON_RELU_EN
        if (r < 0) r = 0;
`endif
        return 16'(r);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, cyc, act, act[15:0], exp, exp[15:0]);
        end
    endtask

    // Cycle monitor: address counter, enable and output pulse timing against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("w_ren", longint'(w_ren), longint'(in_valid));
            check("w_radd", longint'(w_radd), longint'(model_addr));
            if (in_valid) model_addr = (model_addr + 1) % NW;
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                check("out_valid_pulse", longint'(out_valid), 64'sd1);
                check("out_data_model", longint'(out_data), longint'(expq[0].val));
                void'(expq.pop_front());
            end else begin
                check("out_valid_idle", longint'(out_valid), 64'sd0);
            end
            if (out_valid) begin
                pulses++;
                last_out = out_data;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [15:0] d);
        in_data  = d;
        in_valid = 1'b1;
        fsum += longint'(d) * longint'(wmem[fidx]);
        fidx++;
        if (fidx == NW) begin
            expq.push_back('{cyc + 3, ref_out(fsum, bias)});
            fidx = 0;
            fsum = 0;
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic fill_w(input logic signed [15:0] w);
        for (int i = 0; i < NW; i++) wmem[i] = w;
    endtask

    typedef struct {
        logic signed [15:0] w;
        logic signed [15:0] d;
        logic signed [15:0] b;
        logic signed [15:0] exp_lin;
        logic signed [15:0] exp_relu;
        int                 maxgap;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int p0;
        logic signed [15:0] e;

        tbl[0] = '{16'sh0100, 16'sh0100, 16'sh0000, 16'sh0A00, 16'sh0A00, 0};
        tbl[1] = '{16'shFF00, 16'sh0100, 16'sh0000, 16'shF600, 16'sh0000, 0};
        tbl[2] = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 0};
        tbl[3] = '{16'sh8000, 16'sh7FFF, 16'sh0000, 16'sh8000, 16'sh0000, 0};
        tbl[4] = '{16'sh0100, 16'sh0100, 16'sh0080, 16'sh0A80, 16'sh0A80, 3};
        tbl[5] = '{16'shFFFF, 16'sh0001, 16'sh0000, 16'shFFFF, 16'sh0000, 0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'sd0;
        bias     = 16'sd0;
        fill_w(16'sd0);
        repeat (3) step();
        check("reset_out_valid", longint'(out_valid), 64'sd0);
        check("reset_out_data", longint'(out_data), 64'sd0);
        check("reset_w_radd", longint'(w_radd), 64'sd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            fill_w(tbl[i].w);
            bias = tbl[i].b;
            p0 = pulses;
            for (int k = 0; k < NW; k++) begin
                send(tbl[i].d);
                if (tbl[i].maxgap > 0 && k < NW - 1)
                    repeat ($urandom_range(1, tbl[i].maxgap)) step();
            end
            repeat (6) step();
`ifdef NEURON_RELU_EN
            e = tbl[i].exp_relu;
`else
            e = tbl[i].exp_lin;
`endif
            check($sformatf("tbl%0d_pulses", i), longint'(pulses - p0), 64'sd1);
            check($sformatf("tbl%0d_out", i), longint'(last_out), longint'(e));
        end

        // Two frames back to back with no idle cycle
        fill_w(16'sh0100);
        bias = 16'sd0;
        p0 = pulses;
        for (int k = 0; k < NW; k++) send(16'sh0100);
        for (int k = 0; k < NW; k++) send(16'sh0200);
        repeat (6) step();
        check("b2b_pulses", longint'(pulses - p0), 64'sd2);
        check("b2b_second_out", longint'(last_out), 64'sh1400);

        // Reset in the middle of a frame
        for (int k = 0; k < 5; k++) send(16'sh0100);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", longint'(out_valid), 64'sd0);
        check("midrst_out_data", longint'(out_data), 64'sd0);
        check("midrst_w_radd", longint'(w_radd), 64'sd0);
        model_addr = 0;
        fidx = 0;
        fsum = 0;
        expq.delete();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        p0 = pulses;
        for (int k = 0; k < NW; k++) send(16'sh0100);
        repeat (6) step();
        check("postrst_pulses", longint'(pulses - p0), 64'sd1);
        check("postrst_out", longint'(last_out), 64'sh0A00);

        // Random frames checked against the arithmetic model
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NW; i++)
                wmem[i] = (f < 6) ? 16'($urandom_range(0, 1023) - 512) : 16'($urandom);
            bias = 16'($urandom_range(0, 511) - 256);
            for (int k = 0; k < NW; k++) begin
                send((f < 6) ? 16'($urandom_range(0, 1023) - 512) : 16'($urandom));
                repeat ($urandom_range(0, 2)) step();
            end
            repeat (4) step();
        end

        repeat (5) step();
        check("pending_results", longint'(expq.size()), 64'sd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
